// File: rtl/dmem_pipe.sv
// dmem_pipe: single-port data memory with byte-lane writes, READ_LAT-stage read pipe and FWFT response FIFO.
// Latency: read accepted at edge N shows out_rsp_valid after edge N+READ_LAT (FIFO empty); writes respond nothing.
// Backpressure: credits (max RSP_DEPTH reads in flight) gate out_req_ready; FIFO never overflows, nothing dropped.
// Optional build macro MEM_INIT_CLEAR_EN: zero the whole array after every reset before accepting traffic.

// dmem_fifo: first-word-fall-through FIFO holding completed read responses.
// Latency: a push at edge N is visible on vld_o/dat_o right after edge N.
// Backpressure: none internally; callers guarantee no push while full.
module dmem_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  store_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop_ok;

    assign pop_ok = pop_i && (cnt_q != '0);
    assign vld_o  = (cnt_q != '0);
    assign dat_o  = store_q[rd_q];

    // Pointer wrap and occupancy bookkeeping; DEPTH need not be a power of two.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_i) begin
            wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        end
        case ({push_i, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage is reset so the head reads zero while the FIFO is empty after reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                store_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                store_q[wr_q] <= push_dat_i;
            end
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

module dmem_pipe #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int READ_LAT  = 1,
    parameter int RSP_DEPTH = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                in_req_valid,
    output logic                out_req_ready,
    input  logic                in_req_we,
    input  logic [ADDR_W-1:0]   in_req_addr,
    input  logic [DATA_W-1:0]   in_req_wdata,
    input  logic [DATA_W/8-1:0] in_req_be,
    output logic                out_rsp_valid,
    input  logic                in_rsp_ready,
    output logic [DATA_W-1:0]   out_rsp_data,
    output logic                out_init_done
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = $clog2(RSP_DEPTH + 1);

`ifdef MEM_INIT_CLEAR_EN
    typedef enum logic [1:0] {ST_INIT, ST_CLEAR, ST_RUN} state_t;
`else
    typedef enum logic [1:0] {ST_INIT, ST_RUN} state_t;
`endif

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              req_acc;
    logic              rd_acc;
    logic              wr_acc;
    logic              rsp_hs;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [READ_LAT-1:0] pipe_vld_q;
    logic [DATA_W-1:0]   pipe_dat_q [READ_LAT];

`ifdef MEM_INIT_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
`endif

    // Ready depends only on mode and free credits, never on the request payload.
    assign out_req_ready = (state_q == ST_RUN) && (cnt_q < CW'(RSP_DEPTH));
    assign req_acc       = in_req_valid && out_req_ready;
    assign rd_acc        = req_acc && !in_req_we;
    assign wr_acc        = req_acc && in_req_we;
    assign rsp_hs        = out_rsp_valid && in_rsp_ready;
    assign out_init_done = (state_q == ST_RUN);

    // Next-state logic: INIT leaves on the first edge, CLEAR walks the array once.
    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef MEM_INIT_CLEAR_EN
            ST_INIT:  state_d = ST_CLEAR;
            ST_CLEAR: if (clr_addr_q == '1) state_d = ST_RUN;
`else
            ST_INIT:  state_d = ST_RUN;
`endif
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_INIT;
        endcase
    end

    // Mode register; reset always returns to INIT.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MEM_INIT_CLEAR_EN
    // Clear address advances once per CLEAR cycle and naturally wraps back to zero.
    always_comb begin
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
        end
    end

    // Clear address register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            clr_addr_q <= '0;
        end else begin
            clr_addr_q <= clr_addr_d;
        end
    end
`endif

    // Credit count tracks reads accepted but not yet handed to the consumer.
    always_comb begin
        case ({rd_acc, rsp_hs})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Credit register; reset drops all in-flight reads.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Storage array has no reset so its contents survive a reset unless cleared.
    always_ff @(posedge i_clk) begin
`ifdef MEM_INIT_CLEAR_EN
        if (state_q == ST_CLEAR) begin
            mem_q[clr_addr_q] <= '0;
        end
`endif
        if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (in_req_be[i]) begin
                    mem_q[in_req_addr][8*i +: 8] <= in_req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read pipe: stage 0 samples the array at the accept edge, later stages add delay.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pipe_vld_q <= '0;
            for (int k = 0; k < READ_LAT; k++) begin
                pipe_dat_q[k] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= rd_acc;
            if (rd_acc) begin
                pipe_dat_q[0] <= mem_q[in_req_addr];
            end
            for (int k = 1; k < READ_LAT; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_dat_q[k] <= pipe_dat_q[k-1];
            end
        end
    end

    // Response buffer; credits bound occupancy so the push is unconditional.
    dmem_fifo #(
        .W     (DATA_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .push_i     (pipe_vld_q[READ_LAT-1]),
        .push_dat_i (pipe_dat_q[READ_LAT-1]),
        .pop_i      (in_rsp_ready),
        .vld_o      (out_rsp_valid),
        .dat_o      (out_rsp_data)
    );
endmodule

// File: tb/tb_dmem_pipe.sv
// tb_dmem_pipe: scoreboard bench for dmem_pipe (DATA_W=32, ADDR_W=4, READ_LAT=2, RSP_DEPTH=4).
// Expected read data come from a byte-lane model of the array captured at request accept.
// Works with or without MEM_INIT_CLEAR_EN defined.
module tb_dmem_pipe;
    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int RL  = 2;
    localparam int RD  = 4;
    localparam int DEP = 16;
`ifdef MEM_INIT_CLEAR_EN
    localparam int EXP_INIT = DEP + 1;
`else
    localparam int EXP_INIT = 1;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          in_req_valid = 1'b0;
    logic          out_req_ready;
    logic          in_req_we = 1'b0;
    logic [AW-1:0] in_req_addr = '0;
    logic [DW-1:0] in_req_wdata = '0;
    logic [3:0]    in_req_be = '0;
    logic          out_rsp_valid;
    logic          in_rsp_ready = 1'b0;
    logic [DW-1:0] out_rsp_data;
    logic          out_init_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pops = 0;
    int first_pop = 0;
    int last_pop = 0;
    int accepts = 0;

    logic [DW-1:0] model [DEP];
    logic [DW-1:0] sb [$];

    always #5 i_clk = ~i_clk;

    dmem_pipe #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(RL), .RSP_DEPTH(RD)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .in_req_valid  (in_req_valid),
        .out_req_ready (out_req_ready),
        .in_req_we     (in_req_we),
        .in_req_addr   (in_req_addr),
        .in_req_wdata  (in_req_wdata),
        .in_req_be     (in_req_be),
        .out_rsp_valid (out_rsp_valid),
        .in_rsp_ready  (in_rsp_ready),
        .out_rsp_data  (out_rsp_data),
        .out_init_done (out_init_done)
    );

    // One clock: record handshakes seen before the edge, then sample 1 ns after it.
    task automatic step();
        logic          hs_req;
        logic          hs_rsp;
        logic [DW-1:0] d;
        logic [DW-1:0] e;
        hs_req = in_req_valid && out_req_ready;
        hs_rsp = out_rsp_valid && in_rsp_ready;
        d = out_rsp_data;
        if (hs_req && !in_req_we) sb.push_back(model[in_req_addr]);
        if (hs_req && in_req_we) begin
            for (int i = 0; i < 4; i++)
                if (in_req_be[i]) model[in_req_addr][8*i +: 8] = in_req_wdata[8*i +: 8];
        end
        @(posedge i_clk);
        #1;
        cyc++;
        if (hs_req) accepts++;
        if (hs_rsp) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got response %h, none expected", d);
            end else begin
                e = sb.pop_front();
                if (d !== e) begin
                    errors++;
                    $display("FAIL rsp_data: got %h, expected %h", d, e);
                end
            end
            if (pops == 0) first_pop = cyc;
            pops++;
            last_pop = cyc;
        end
    endtask

    task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [3:0] be, output logic ok);
        logic acc;
        int   n;
        in_req_valid = 1'b1; in_req_we = we; in_req_addr = a; in_req_wdata = wd; in_req_be = be;
        n = 0;
        do begin
            acc = out_req_ready;
            step();
            n++;
        end while (!acc && n < 100);
        in_req_valid = 1'b0;
        ok = acc;
    endtask

    task automatic drain(output logic ok);
        int n;
        in_rsp_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        ok = (sb.size() == 0);
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!out_init_done && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (out_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, expected 0", out_req_ready); end
        checks++; if (out_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, expected 0", out_rsp_valid); end
        checks++; if (out_rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h, expected 0", out_rsp_data); end
        checks++; if (out_init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b, expected 0", out_init_done); end
        i_rst = 1'b1;
        wait_init(n);
        checks++; if (n != EXP_INIT) begin errors++; $display("FAIL init_latency: got %0d edges, expected %0d", n, EXP_INIT); end
        checks++; if (out_req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_init: got %b, expected 1", out_req_ready); end
    endtask

    task automatic test_clear();
        logic ok;
        do_req(1'b0, 4'd5, '0, 4'h0, ok);
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL clear_drain: got timeout, expected response"); end
    endtask

    task automatic test_fill();
        logic ok;
        for (int i = 0; i < DEP; i++) do_req(1'b1, AW'(i), 32'hA000_0000 + i * 32'h0001_0101, 4'hF, ok);
    endtask

    task automatic test_byte_lanes();
        logic ok;
        int   lat;
        do_req(1'b1, 4'd3, 32'hDEADBEEF, 4'hF, ok);
        do_req(1'b1, 4'd3, 32'h000000AA, 4'h1, ok);
        do_req(1'b1, 4'd3, 32'hFFFFFFFF, 4'h0, ok);
        in_rsp_ready = 1'b1;
        do_req(1'b0, 4'd3, '0, 4'h0, ok);
        lat = 0;
        while (!out_rsp_valid && lat < 20) begin step(); lat++; end
        checks++; if (lat != RL) begin errors++; $display("FAIL read_latency: got %0d, expected %0d", lat, RL); end
        checks++; if (out_rsp_data !== 32'hDEADBEAA) begin errors++; $display("FAIL byte_merge: got %h, expected deadbeaa", out_rsp_data); end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL byte_drain: got timeout, expected response"); end
    endtask

    task automatic test_back_to_back();
        logic ok;
        int   drops;
        drops = 0;
        pops = 0;
        in_rsp_ready = 1'b1;
        for (int a = 0; a < 8; a++) begin
            in_req_valid = 1'b1; in_req_we = 1'b0; in_req_addr = AW'(a); in_req_be = 4'h0;
            if (!out_req_ready) drops++;
            step();
        end
        in_req_valid = 1'b0;
        drain(ok);
        checks++; if (drops != 0) begin errors++; $display("FAIL b2b_ready: got %0d stalls, expected 0", drops); end
        checks++; if (pops != 8) begin errors++; $display("FAIL b2b_count: got %0d, expected 8", pops); end
        checks++; if (last_pop - first_pop != 7) begin errors++; $display("FAIL b2b_spacing: got span %0d, expected 7", last_pop - first_pop); end
    endtask

    task automatic test_backpressure();
        logic          ok;
        logic          stable;
        logic [DW-1:0] head;
        in_rsp_ready = 1'b0;
        accepts = 0;
        for (int k = 0; k < 8; k++) begin
            in_req_valid = 1'b1; in_req_we = 1'b0; in_req_addr = AW'(k + 8); in_req_be = 4'h0;
            step();
        end
        in_req_valid = 1'b0;
        checks++; if (accepts != RD) begin errors++; $display("FAIL bp_accepts: got %0d, expected %0d", accepts, RD); end
        checks++; if (out_req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b, expected 0", out_req_ready); end
        checks++; if (out_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got %b, expected 1", out_rsp_valid); end
        head = out_rsp_data;
        stable = 1'b1;
        repeat (3) begin step(); if (out_rsp_data !== head) stable = 1'b0; end
        checks++; if (!stable) begin errors++; $display("FAIL bp_head_stable: got %h, expected %h", out_rsp_data, head); end
        pops = 0;
        drain(ok);
        checks++; if (pops != RD) begin errors++; $display("FAIL bp_release: got %0d responses, expected %0d", pops, RD); end
        checks++; if (out_req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b, expected 1", out_req_ready); end
    endtask

    task automatic test_hazard();
        logic ok;
        in_rsp_ready = 1'b1;
        do_req(1'b1, 4'd9, 32'hCAFEF00D, 4'hF, ok);
        do_req(1'b0, 4'd9, '0, 4'h0, ok);
        do_req(1'b0, 4'd9, '0, 4'h0, ok);
        do_req(1'b1, 4'd9, 32'h12345678, 4'hF, ok);
        do_req(1'b0, 4'd9, '0, 4'h0, ok);
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL hazard_drain: got timeout, expected responses"); end
    endtask

    task automatic test_reset_midop();
        logic ok;
        int   n;
        in_rsp_ready = 1'b0;
        in_req_valid = 1'b1; in_req_we = 1'b0; in_req_addr = 4'd0; in_req_be = 4'h0;
        step();
        in_req_addr = 4'd1;
        step();
        in_req_valid = 1'b0;
        i_rst = 1'b0;
        #1;
        checks++; if (out_rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, expected 0", out_rsp_valid); end
        checks++; if (out_req_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b, expected 0", out_req_ready); end
        sb.delete();
`ifdef MEM_INIT_CLEAR_EN
        for (int i = 0; i < DEP; i++) model[i] = '0;
`endif
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        wait_init(n);
        checks++; if (n != EXP_INIT) begin errors++; $display("FAIL midrst_init: got %0d edges, expected %0d", n, EXP_INIT); end
        in_rsp_ready = 1'b1;
        pops = 0;
        repeat (8) step();
        checks++; if (pops != 0) begin errors++; $display("FAIL midrst_stale: got %0d responses, expected 0", pops); end
        in_rsp_ready = 1'b0;
        accepts = 0;
        in_req_valid = 1'b1; in_req_we = 1'b0; in_req_addr = 4'd3; in_req_be = 4'h0;
        repeat (6) step();
        in_req_valid = 1'b0;
        checks++; if (accepts != RD) begin errors++; $display("FAIL midrst_credits: got %0d accepts, expected %0d", accepts, RD); end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_drain: got timeout, expected responses"); end
    endtask

    initial begin
        for (int i = 0; i < DEP; i++) begin
`ifdef MEM_INIT_CLEAR_EN
            model[i] = '0;
`else
            model[i] = 'x;
`endif
        end
        test_reset();
`ifdef MEM_INIT_CLEAR_EN
        test_clear();
`endif
        test_fill();
        test_byte_lanes();
        test_back_to_back();
        test_backpressure();
        test_hazard();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
